// File: rtl/wb_retire_unit.sv
// Write-back select, register-file write gating, retire counting and halt sequencing.
// Define RETIRE_TRACE_EN to build the retirement trace FIFO and valid/ready debug port.
module wb_retire_unit #(
  parameter int unsigned TRACE_DEPTH = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic             wb_RegWrite,
  input  logic             wb_MemtoReg,
  input  logic             wb_RWSel,
  input  logic [31:0]      wb_Pc_Four,
  input  logic [31:0]      wb_Alu_Result,
  input  logic [31:0]      wb_MemReadData,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_Curr_Instr,
  input  logic             wb_Halt_detect,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             halted,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [31:0]      trace_instr,
  output logic [4:0]       trace_rd,
  output logic [31:0]      trace_wdata,
  output logic [15:0]      trace_drops
);

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             trace_empty;

  always_comb begin
    rf_waddr = wb_rd;
    if (wb_RWSel)        rf_wdata = wb_Pc_Four;
    else if (wb_MemtoReg) rf_wdata = wb_MemReadData;
    else                  rf_wdata = wb_Alu_Result;
    rf_we  = wb_valid & wb_RegWrite & (wb_rd != '0) & ~wb_Halt_detect & (state_q == RUN);
    retire = wb_valid & (state_q == RUN);
    cnt_d  = cnt_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (retire && wb_Halt_detect) state_d = FLUSH;
      FLUSH:   if (trace_empty) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    halted      = (state_q == HALTED);
    retired_cnt = cnt_q;
  end

`ifdef RETIRE_TRACE_EN
  localparam int unsigned AW = $clog2(TRACE_DEPTH);
  localparam int unsigned FW = AW + 1;

  logic [68:0]   mem_q [TRACE_DEPTH];
  logic [68:0]   entry_in;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [15:0]   drops_q, drops_d;
  logic          push, pop, full, push_ok, drop;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    push     = retire & ~wb_Halt_detect;
    pop      = (fill_q != '0) & trace_ready;
    full     = (fill_q == FW'(TRACE_DEPTH));
    push_ok  = push & (~full | pop);
    drop     = push & full & ~pop;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    fill_d   = fill_q + FW'(push_ok) - FW'(pop);
    drops_d  = drops_q;
    if (drop && (drops_q != '1)) drops_d = drops_q + 16'd1;
    entry_in = {wb_Curr_Instr, rf_we ? wb_rd : 5'd0, rf_we ? rf_wdata : 32'd0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      drops_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      drops_q  <= drops_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= entry_in;
  end

  // Payload is masked by valid so an empty or freshly reset FIFO presents zeros.
  always_comb begin
    trace_empty = (fill_q == '0);
    trace_valid = ~trace_empty;
    {trace_instr, trace_rd, trace_wdata} = trace_valid ? mem_q[rd_ptr_q] : '0;
    trace_drops = drops_q;
  end
`else
  logic unused_trace;

  always_comb begin
    trace_empty  = 1'b1;
    trace_valid  = 1'b0;
    trace_instr  = '0;
    trace_rd     = '0;
    trace_wdata  = '0;
    trace_drops  = '0;
    unused_trace = trace_ready | (^wb_Curr_Instr) | (TRACE_DEPTH == 0);
  end
`endif

endmodule

// File: tb/tb_wb_retire_unit.sv
// Scoreboard bench for wb_retire_unit: register writes and trace entries are
// queued at issue and checked by a monitor when the DUT presents them.
module tb_wb_retire_unit;

`ifdef RETIRE_TRACE_EN
  localparam logic TR = 1'b1;
`else
  localparam logic TR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_RegWrite, wb_MemtoReg, wb_RWSel, wb_Halt_detect;
  logic [31:0] wb_Pc_Four, wb_Alu_Result, wb_MemReadData, wb_Curr_Instr;
  logic [4:0]  wb_rd;
  logic        rf_we, halted, trace_valid, trace_ready;
  logic [4:0]  rf_waddr, trace_rd;
  logic [31:0] rf_wdata, retired_cnt, trace_instr, trace_wdata;
  logic [15:0] trace_drops;

  int total = 0;
  int bad   = 0;

  logic [36:0] wq[$];
  logic [68:0] tq[$];
  logic [36:0] wexp;
  logic [68:0] texp;

  wb_retire_unit #(.TRACE_DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_RWSel(wb_RWSel), .wb_Pc_Four(wb_Pc_Four), .wb_Alu_Result(wb_Alu_Result),
    .wb_MemReadData(wb_MemReadData), .wb_rd(wb_rd), .wb_Curr_Instr(wb_Curr_Instr),
    .wb_Halt_detect(wb_Halt_detect),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retired_cnt(retired_cnt), .halted(halted),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_instr(trace_instr), .trace_rd(trace_rd), .trace_wdata(trace_wdata),
    .trace_drops(trace_drops)
  );

  always #5 clk = ~clk;

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (rf_we) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL rf_write: got unexpected waddr=%0d wdata=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        wexp = wq.pop_front();
        if ({rf_waddr, rf_wdata} !== wexp) begin
          bad++;
          $display("FAIL rf_write: got waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                   rf_waddr, rf_wdata, wexp[36:32], wexp[31:0]);
        end
      end
    end
    if (trace_valid && trace_ready) begin
      total++;
      if (tq.size() == 0) begin
        bad++;
        $display("FAIL trace_pop: got unexpected instr=%h, required no entry", trace_instr);
      end else begin
        texp = tq.pop_front();
        if ({trace_instr, trace_rd, trace_wdata} !== texp) begin
          bad++;
          $display("FAIL trace_pop: got instr=%h rd=%0d wdata=%h, required instr=%h rd=%0d wdata=%h",
                   trace_instr, trace_rd, trace_wdata, texp[68:37], texp[36:32], texp[31:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic v, input logic rw, input logic m2r, input logic rws,
                      input logic [31:0] pc4, input logic [31:0] alu, input logic [31:0] mrd,
                      input logic [4:0] rd, input logic [31:0] instr, input logic hlt,
                      input logic exp_we, input logic [31:0] exp_wd, input logic exp_tr);
    wb_valid = v; wb_RegWrite = rw; wb_MemtoReg = m2r; wb_RWSel = rws;
    wb_Pc_Four = pc4; wb_Alu_Result = alu; wb_MemReadData = mrd;
    wb_rd = rd; wb_Curr_Instr = instr; wb_Halt_detect = hlt;
    if (exp_we) wq.push_back({rd, exp_wd});
    if (TR && exp_tr) tq.push_back({instr, exp_we ? rd : 5'd0, exp_we ? exp_wd : 32'd0});
    @(posedge clk); #1;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] instr,
                        input logic exp_we, input logic exp_tr);
    send(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0004, alu, 32'h0, rd, instr, 1'b0, exp_we, alu, exp_tr);
  endtask

  task automatic idle(input int n);
    wb_valid = 1'b0; wb_Halt_detect = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; trace_ready = 1'b0;
    wb_valid = 0; wb_RegWrite = 0; wb_MemtoReg = 0; wb_RWSel = 0; wb_Halt_detect = 0;
    wb_Pc_Four = '0; wb_Alu_Result = '0; wb_MemReadData = '0; wb_rd = '0; wb_Curr_Instr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_cnt", retired_cnt, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_tvalid", {31'd0, trace_valid}, 32'd0);
    chk("reset_drops", {16'd0, trace_drops}, 32'd0);
    chk("reset_tinstr", trace_instr, 32'd0);

    // Write-data select, x0 and bubbles
    trace_ready = 1'b1;
    send(1, 1, 0, 0, 32'h8, 32'h1234, 32'h5555, 5'd5, 32'h00A0_0293, 0, 1, 32'h1234, 1);
    chk("cnt_latency", retired_cnt, 32'd1);
    send(1, 1, 1, 0, 32'hC, 32'h100, 32'hDEAD_BEEF, 5'd6, 32'h0002_A303, 0, 1, 32'hDEAD_BEEF, 1);
    send(1, 1, 1, 1, 32'h44, 32'h66, 32'h55, 5'd1, 32'h0080_00EF, 0, 1, 32'h44, 1);
    send(1, 1, 0, 0, 32'h14, 32'h77, 32'h0, 5'd0, 32'h0770_0013, 0, 0, 32'h0, 1);
    send(0, 1, 0, 0, 32'h18, 32'h88, 32'h0, 5'd7, 32'h0880_0393, 0, 0, 32'h0, 0);
    idle(3);
    chk("cnt_basic", retired_cnt, 32'd4);
    chk("tvalid_drained", {31'd0, trace_valid}, 32'd0);

    // Backpressure: 10 retires into an 8-deep FIFO
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      alu_op(5'(10 + i), 32'h1000 + 32'(i), 32'h100 + 32'(i), 1'b1, i < 8);
    chk("cnt_bp", retired_cnt, 32'd14);
    chk("drops_bp", {16'd0, trace_drops}, TR ? 32'd2 : 32'd0);
    chk("tvalid_bp", {31'd0, trace_valid}, {31'd0, TR});
    trace_ready = 1'b1;
    alu_op(5'd20, 32'h2000, 32'h0000_0200, 1'b1, 1'b1);
    chk("drops_simul", {16'd0, trace_drops}, TR ? 32'd2 : 32'd0);
    trace_ready = 1'b0;
    alu_op(5'd21, 32'h2100, 32'h0000_0210, 1'b1, 1'b0);
    chk("drops_full_probe", {16'd0, trace_drops}, TR ? 32'd3 : 32'd0);
    trace_ready = 1'b1;
    idle(10);
    chk("tvalid_drain2", {31'd0, trace_valid}, 32'd0);
    chk("cnt_bp2", retired_cnt, 32'd16);

    // Halt sequence with empty FIFO afterwards
    alu_op(5'd1, 32'h11, 32'h0110_0093, 1'b1, 1'b1);
    alu_op(5'd2, 32'h22, 32'h0220_0113, 1'b1, 1'b1);
    alu_op(5'd3, 32'h33, 32'h0330_0193, 1'b1, 1'b1);
    send(1, 1, 0, 0, 32'h4, 32'h99, 32'h0, 5'd9, 32'h0010_0073, 1, 0, 32'h0, 0);
    chk("halted_n1", {31'd0, halted}, 32'd0);
    chk("cnt_halt", retired_cnt, 32'd20);
    alu_op(5'd10, 32'hAA, 32'h0AA0_0513, 1'b0, 1'b0);
    chk("halted_n2", {31'd0, halted}, 32'd1);
    alu_op(5'd11, 32'hBB, 32'h0BB0_0593, 1'b0, 1'b0);
    chk("cnt_after_halt", retired_cnt, 32'd20);
    chk("halted_hold", {31'd0, halted}, 32'd1);
    idle(1);

    // Reset out of HALTED, then reset during FLUSH with pending trace entries
    reset = 1'b1;
    tq.delete();
    @(posedge clk); #1 reset = 1'b0;
    chk("rst2_cnt", retired_cnt, 32'd0);
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    trace_ready = 1'b0;
    alu_op(5'd12, 32'h12, 32'h0120_0613, 1'b1, 1'b1);
    alu_op(5'd13, 32'h13, 32'h0130_0693, 1'b1, 1'b1);
    send(1, 1, 0, 0, 32'h4, 32'h99, 32'h0, 5'd9, 32'h0010_0073, 1, 0, 32'h0, 0);
    idle(2);
    chk("flush_hold", {31'd0, halted}, TR ? 32'd0 : 32'd1);
    chk("cnt_pre_reset", retired_cnt, 32'd3);
    #2 reset = 1'b1;
    tq.delete();
    #1;
    chk("async_rst_halted", {31'd0, halted}, 32'd0);
    chk("async_rst_tvalid", {31'd0, trace_valid}, 32'd0);
    chk("async_rst_cnt", retired_cnt, 32'd0);
    chk("async_rst_tinstr", trace_instr, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    trace_ready = 1'b1;
    alu_op(5'd4, 32'hCAFE, 32'h0CAF_E213, 1'b1, 1'b1);
    chk("fresh_cnt", retired_cnt, 32'd1);
    idle(3);
    chk("fresh_halted", {31'd0, halted}, 32'd0);
    chk("wq_empty", wq.size(), 32'd0);
    chk("tq_empty", tq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_retire_unit.md
# wb_retire_unit

Write-back and retirement unit for the 5-stage RISC-V pipeline. Consumes the MEM/WB pipeline register fields, selects the register-file write data and gates the write port. Counts retired instructions and runs the halt sequence when a halt-marked instruction reaches write-back. Optionally streams a retirement trace through a small FIFO to a valid/ready debug port.

## Interface
- TRACE_DEPTH, 8: trace FIFO entries; power of two, 2..64.
- CNT_W, 32: retired-instruction counter width.
---
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- wb_valid  in  1  MEM/WB holds a real instruction, not a bubble.
- wb_RegWrite  in  1  instruction writes rd.
- wb_MemtoReg  in  1  select MemReadData over Alu_Result.
- wb_RWSel  in  1  select Pc_Four (link value); overrides MemtoReg.
- wb_Pc_Four  in  32  PC+4 of the instruction.
- wb_Alu_Result  in  32  ALU result.
- wb_MemReadData  in  32  load data.
- wb_rd  in  5  destination register.
- wb_Curr_Instr  in  32  instruction word.
- wb_Halt_detect  in  1  instruction is the halt marker.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data; also the forwarding source.
- retired_cnt  out  CNT_W  retired-instruction count.
- halted  out  1  pipeline has halted.
- trace_valid  out  1  trace entry available.
- trace_ready  in  1  consumer accepts the entry.
- trace_instr  out  32  traced instruction word.
- trace_rd  out  5  traced rd; 0 if no write.
- trace_wdata  out  32  traced write data; 0 if no write.
- trace_drops  out  16  entries lost to a full FIFO; saturates at 0xFFFF.

## Operation
- Write data: rf_wdata = wb_RWSel ? wb_Pc_Four : (wb_MemtoReg ? wb_MemReadData : wb_Alu_Result). rf_waddr = wb_rd.
- rf_we = wb_valid & wb_RegWrite & (wb_rd != 0) & ~wb_Halt_detect & (state == RUN).
- Retire event: wb_valid & (state == RUN). Increments retired_cnt, including the halt instruction. Wraps modulo 2^CNT_W.
- FSM states:
  - RUN: if a retire event has wb_Halt_detect, go to FLUSH.
  - FLUSH: all writes and retires are suppressed. When the trace FIFO is empty, go to HALTED.
  - HALTED: terminal; exits only via reset.
- halted = 1 in HALTED only.
- Trace enqueue: every retire event, except halt instructions, pushes {wb_Curr_Instr, rf_we ? rd : 0, rf_we ? wdata : 0}.
- FIFO full on enqueue: the entry is dropped and trace_drops increments (saturating).
- Simultaneous push and pop when full: the pop frees a slot, so the push succeeds and nothing is dropped.
- Handshake: an entry pops when trace_valid & trace_ready. While trace_valid is high, its payload is held stable until the pop.

## Timing
- rf_we, rf_waddr and rf_wdata are combinational from the wb_* inputs in the same cycle. The register file writes at the same rising edge.
- retired_cnt updates at the edge that ends the retire cycle, i.e. 1 cycle of latency.
- Halt instruction in WB in cycle N:
  - FLUSH from N+1.
  - With an empty FIFO, halted = 1 from N+2.
  - Otherwise halted rises 1 cycle after the last pop.
- Trace: an entry pushed at edge N shows trace_valid from cycle N+1 (first-word-fall-through, registered).
- Reset, any cycle:
  - State returns to RUN and the FIFO empties.
  - retired_cnt = 0, trace_drops = 0, halted = 0, trace_valid = 0, trace payload = 0.
  - rf_* still follow the inputs, but rf_we is gated only by the conditions above.

## Configuration
- RETIRE_TRACE_EN defined: trace FIFO, handshake and drop counter are built as above.
- RETIRE_TRACE_EN undefined:
  - No FIFO is instantiated.
  - trace_valid, trace_instr, trace_rd, trace_wdata and trace_drops are tied to 0; trace_ready is ignored.
  - FLUSH always lasts exactly one cycle.

## Test plan
- Write-data select:
  - ALU op rd=5, Alu_Result=0x1234 -> rf_we=1, waddr=5, wdata=0x1234.
  - Load, MemtoReg=1, MemReadData=0xDEADBEEF -> wdata=0xDEADBEEF.
  - RWSel=1, Pc_Four=0x44 -> wdata=0x44.
- x0 and bubbles:
  - rd=0 with RegWrite=1 -> rf_we=0, retired_cnt +1.
  - wb_valid=0 -> no write, count unchanged.
- Halt: 3 instructions, then halt, then 2 more valid instructions, trace_ready=1 -> retired_cnt=4, rf_we=0 for the last two, halted=1 two cycles after the halt reaches WB.
- Trace backpressure (TRACE_DEPTH=8, trace_ready=0), 10 retires -> 8 entries held, trace_drops=2. Raising trace_ready pops them in order with unchanged payloads.
- Full FIFO with simultaneous push and pop -> count stays 8, no drop.
- Reset asserted in FLUSH with a non-empty FIFO -> immediate RUN, trace_valid=0, retired_cnt=0, halted=0. A fresh instruction then retires normally.
